regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port general-purpose register file. Successor to the current 2R1W array.
- Configurable numbers of read and write ports, word width and depth.
- Optional hardwired-zero register 0 and optional write-to-read bypass.
- Sequential soft-clear engine: zeroes the array one entry per cycle without asserting reset. Sits between decode (reads) and writeback (writes) in the core pipeline.

Parameters:
- DATA_WIDTH, 32, bits per register word.
- ADDR_WIDTH, 5, address bits; NUM_WORDS = 2**ADDR_WIDTH.
- NUM_RPORTS, 2, number of read ports (>=1).
- NUM_WPORTS, 1, number of write ports (>=1).
- ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes.
- BYPASS, 0, 1 = read port returns same-cycle write data on an address match.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset; asynchronous, active-low.
- clear_i  in  1  pulse to start a soft clear of the whole array.
- busy_o  out  1  high while soft clear is in progress.
- raddr_i  in  NUM_RPORTS x ADDR_WIDTH  read addresses.
- rdata_o  out  NUM_RPORTS x DATA_WIDTH  read data.
- waddr_i  in  NUM_WPORTS x ADDR_WIDTH  write addresses.
- wdata_i  in  NUM_WPORTS x DATA_WIDTH  write data.
- we_i  in  NUM_WPORTS  per-port write enable.

Behaviour:
- Reset (rst_ni=0, async):
  - all NUM_WORDS entries <= 0
  - FSM <= IDLE
  - clear pointer <= 0
  - busy_o = 0
  - rdata_o reflects the zeroed array, i.e. 0.
- Reads are combinational from the registered array (0-cycle latency).
- Writes take effect at the rising edge: data written at edge N is visible on rdata_o after edge N.
- Write conflict: when several ports have we_i=1 and the same waddr_i, the highest-index port wins. Writes to different addresses all commit in the same cycle.
- ZERO_REG=1:
  - address 0 always reads 0;
  - writes to address 0 are dropped, including the bypass path.
  - ZERO_REG=0: entry 0 is an ordinary register.
- BYPASS=1:
  - if a read address equals an active write address, rdata_o returns the winning wdata_i in the same cycle, not the array value;
  - ZERO_REG takes precedence over the bypass.
  - BYPASS=0: a read always returns the array value, i.e. old data during a same-address write.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR when clear_i=1 at a clock edge. Clear pointer <= 0 on entry; busy_o goes high from the next cycle.
  - CLEAR: each cycle the entry at the pointer <= 0 and the pointer increments.
  - CLEAR -> IDLE on the cycle the pointer equals NUM_WORDS-1, after that entry is zeroed. Pointer wraps to 0.
  - busy_o is high for exactly NUM_WORDS cycles.
- While busy_o=1:
  - all we_i are ignored (writes dropped, no bypass);
  - rdata_o = 0 on all ports;
  - clear_i is ignored (no restart, no extension).
- clear_i held high continuously: after returning to IDLE, a new clear starts at the next edge.
- rst_ni asserted mid-clear: the array is zeroed immediately, FSM -> IDLE, busy_o=0.
- Out-of-range addresses cannot occur; depth is a power of two.

Test Plan:
- Defaults: write 0xDEADBEEF to reg 5 -> next cycle raddr_i[0]=5 reads 0xDEADBEEF; raddr_i[1]=6 reads 0.
- ZERO_REG=1: write 0x12345678 to reg 0 -> reg 0 reads 0, both same cycle and after.
- ZERO_REG=0: the same write -> reg 0 reads 0x12345678 after the edge.
- NUM_WPORTS=2: port0 writes 0x1111 and port1 writes 0x2222, both to reg 3 in the same cycle -> reg 3 reads 0x2222. With BYPASS=1, same-cycle read of reg 3 returns 0x2222; with BYPASS=0 it returns the old value.
- Fill regs 1..31 with value=index, pulse clear_i for one cycle:
  - busy_o high for exactly 32 cycles;
  - rdata_o=0 throughout;
  - a write of 0xAA to reg 7 mid-clear is dropped;
  - after busy_o falls all regs read 0.
- Assert rst_ni=0 for one cycle in clear cycle 10 -> busy_o=0 immediately, all regs read 0, a new clear_i pulse restarts the full 32-cycle clear.
- NUM_RPORTS=4, all ports read distinct regs 1,2,3,4 holding 0xA,0xB,0xC,0xD -> outputs 0xA,0xB,0xC,0xD in the same cycle.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port register file with optional hardwired-zero entry, optional
// write-to-read bypass and a soft-clear engine that zeroes one entry per cycle.
//
// state | meaning
// IDLE  | normal operation: reads from array, writes commit at the edge
// CLEAR | sweeping the array to zero; writes dropped, reads return 0
module regfile_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_RPORTS = 2,
    parameter int NUM_WPORTS = 1,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 0
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             clear_i,
    output logic                             busy_o,
    input  logic [NUM_RPORTS*ADDR_WIDTH-1:0] raddr_i,
    output logic [NUM_RPORTS*DATA_WIDTH-1:0] rdata_o,
    input  logic [NUM_WPORTS*ADDR_WIDTH-1:0] waddr_i,
    input  logic [NUM_WPORTS*DATA_WIDTH-1:0] wdata_i,
    input  logic [NUM_WPORTS-1:0]            we_i
);
    localparam int NUM_WORDS = 2**ADDR_WIDTH;

    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [DATA_WIDTH-1:0] mem_q [NUM_WORDS];
    logic [DATA_WIDTH-1:0] mem_d [NUM_WORDS];
    logic [NUM_WPORTS-1:0] wr_ok;

    // A write is live only when idle and, with a zero register, not aimed at entry 0.
    always_comb begin
        wr_ok = '0;
        for (int w = 0; w < NUM_WPORTS; w++) begin
            wr_ok[w] = we_i[w] && (state_q == IDLE);
            if (ZERO_REG != 0 && waddr_i[w*ADDR_WIDTH +: ADDR_WIDTH] == '0) begin
                wr_ok[w] = 1'b0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (clear_i) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                end
            end
            CLEAR: begin
                ptr_d = ptr_q + ADDR_WIDTH'(1);
                if (ptr_q == ADDR_WIDTH'(NUM_WORDS - 1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Ports are applied in ascending order so the highest-index port wins a conflict.
    always_comb begin
        mem_d = mem_q;
        if (state_q == CLEAR) begin
            mem_d[ptr_q] = '0;
        end
        for (int w = 0; w < NUM_WPORTS; w++) begin
            if (wr_ok[w]) begin
                mem_d[waddr_i[w*ADDR_WIDTH +: ADDR_WIDTH]] = wdata_i[w*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            for (int i = 0; i < NUM_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            for (int i = 0; i < NUM_WORDS; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign busy_o = (state_q == CLEAR);

    always_comb begin
        rdata_o = '0;
        for (int r = 0; r < NUM_RPORTS; r++) begin
            if (state_q == IDLE &&
                !(ZERO_REG != 0 && raddr_i[r*ADDR_WIDTH +: ADDR_WIDTH] == '0)) begin
                rdata_o[r*DATA_WIDTH +: DATA_WIDTH] = mem_q[raddr_i[r*ADDR_WIDTH +: ADDR_WIDTH]];
                if (BYPASS != 0) begin
                    for (int w = 0; w < NUM_WPORTS; w++) begin
                        if (wr_ok[w] && waddr_i[w*ADDR_WIDTH +: ADDR_WIDTH] ==
                                        raddr_i[r*ADDR_WIDTH +: ADDR_WIDTH]) begin
                            rdata_o[r*DATA_WIDTH +: DATA_WIDTH] = wdata_i[w*DATA_WIDTH +: DATA_WIDTH];
                        end
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: four 4R/2W instances covering every ZERO_REG/BYPASS
// combination plus one default-parameter instance, checked against an array model.
module tb_regfile_mp;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         clear = 1'b0;
    logic [19:0]  raddr = '0;
    logic [9:0]   waddr = '0;
    logic [63:0]  wdata = '0;
    logic [1:0]   we = '0;
    logic [3:0][127:0] rdata_g;
    logic [3:0]        busy_g;
    logic [63:0]  rdata_d;
    logic         busy_d;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] ref_mem [5][32];
    int          busy_left;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        regfile_mp #(.NUM_RPORTS(4), .NUM_WPORTS(2), .ZERO_REG(g / 2), .BYPASS(g % 2)) u_dut (
            .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .busy_o(busy_g[g]),
            .raddr_i(raddr), .rdata_o(rdata_g[g]),
            .waddr_i(waddr), .wdata_i(wdata), .we_i(we));
    end

    regfile_mp u_def (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .busy_o(busy_d),
        .raddr_i(raddr[9:0]), .rdata_o(rdata_d),
        .waddr_i(waddr[4:0]), .wdata_i(wdata[31:0]), .we_i(we[0:0]));

    // Instance 4 is the default one (2R/1W, zero register, no bypass).
    function automatic bit zr(int g); return (g == 4) || (g / 2 == 1); endfunction
    function automatic bit bp(int g); return (g != 4) && (g % 2 == 1); endfunction
    function automatic int nw(int g); return (g == 4) ? 1 : 2; endfunction
    function automatic int nr(int g); return (g == 4) ? 2 : 4; endfunction
    function automatic logic [4:0]  ra(int r); return raddr[r*5 +: 5]; endfunction
    function automatic logic [4:0]  wa(int w); return waddr[w*5 +: 5]; endfunction
    function automatic logic [31:0] wd(int w); return wdata[w*32 +: 32]; endfunction

    function automatic logic [31:0] got_rd(int g, int r);
        return (g == 4) ? rdata_d[r*32 +: 32] : rdata_g[g][r*32 +: 32];
    endfunction
    function automatic logic got_busy(int g);
        return (g == 4) ? busy_d : busy_g[g];
    endfunction

    function automatic logic [31:0] exp_rd(int g, int r);
        logic [4:0] a;
        a = ra(r);
        if (busy_left > 0) return 32'h0;
        if (zr(g) && a == 5'd0) return 32'h0;
        if (bp(g)) begin
            for (int w = nw(g) - 1; w >= 0; w--) begin
                if (we[w] && wa(w) == a) return wd(w);
            end
        end
        return ref_mem[g][a];
    endfunction

    task automatic model_reset();
        busy_left = 0;
        for (int g = 0; g < 5; g++) for (int i = 0; i < 32; i++) ref_mem[g][i] = 32'h0;
    endtask

    // The model wipes the whole array when a clear starts: nothing can observe
    // the entries while busy, and it ends all-zero either way.
    task automatic step();
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else if (busy_left > 0) begin
            busy_left--;
        end else begin
            for (int g = 0; g < 5; g++)
                for (int w = 0; w < nw(g); w++)
                    if (we[w] && !(zr(g) && wa(w) == 5'd0)) ref_mem[g][wa(w)] = wd(w);
            if (clear) begin
                busy_left = 32;
                for (int g = 0; g < 5; g++) for (int i = 0; i < 32; i++) ref_mem[g][i] = 32'h0;
            end
        end
        #1;
    endtask

    task automatic wr1(logic [4:0] a, logic [31:0] d);
        we = 2'b01; waddr[4:0] = a; wdata[31:0] = d;
        step();
        we = 2'b00;
    endtask

    task automatic test_reset();
        model_reset();
        raddr = {5'd5, 5'd3, 5'd1, 5'd0};
        #2;
        for (int g = 0; g < 5; g++) begin
            n_cmp++;
            if (got_busy(g) !== 1'b0) begin
                n_err++; $display("FAIL reset_busy: dut%0d got %b exp 0", g, got_busy(g));
            end
            for (int r = 0; r < nr(g); r++) begin
                n_cmp++;
                if (got_rd(g, r) !== 32'h0) begin
                    n_err++; $display("FAIL reset_rdata: dut%0d p%0d got %h exp 0", g, r, got_rd(g, r));
                end
            end
        end
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_defaults();
        wr1(5'd5, 32'hDEADBEEF);
        raddr[4:0] = 5'd5; raddr[9:5] = 5'd6;
        #1;
        for (int g = 0; g < 5; g++) begin
            n_cmp += 2;
            if (got_rd(g, 0) !== 32'hDEADBEEF) begin
                n_err++; $display("FAIL write_read: dut%0d got %h exp deadbeef", g, got_rd(g, 0));
            end
            if (got_rd(g, 1) !== 32'h0) begin
                n_err++; $display("FAIL unwritten: dut%0d got %h exp 0", g, got_rd(g, 1));
            end
        end
    endtask

    task automatic test_zero_reg();
        logic [31:0] e;
        we = 2'b01; waddr[4:0] = 5'd0; wdata[31:0] = 32'h12345678; raddr[4:0] = 5'd0;
        #1;
        for (int g = 0; g < 5; g++) begin
            e = (g == 1) ? 32'h12345678 : 32'h0;
            n_cmp++;
            if (got_rd(g, 0) !== e) begin
                n_err++; $display("FAIL zero_same_cycle: dut%0d got %h exp %h", g, got_rd(g, 0), e);
            end
        end
        step();
        we = 2'b00;
        #1;
        for (int g = 0; g < 5; g++) begin
            e = zr(g) ? 32'h0 : 32'h12345678;
            n_cmp++;
            if (got_rd(g, 0) !== e) begin
                n_err++; $display("FAIL zero_after: dut%0d got %h exp %h", g, got_rd(g, 0), e);
            end
        end
    endtask

    task automatic test_conflict();
        logic [31:0] e;
        wr1(5'd3, 32'h3333);
        we = 2'b11; waddr = {5'd3, 5'd3}; wdata = {32'h2222, 32'h1111}; raddr[4:0] = 5'd3;
        #1;
        for (int g = 0; g < 5; g++) begin
            e = bp(g) ? 32'h2222 : 32'h3333;
            n_cmp++;
            if (got_rd(g, 0) !== e) begin
                n_err++; $display("FAIL conflict_same_cycle: dut%0d got %h exp %h", g, got_rd(g, 0), e);
            end
        end
        step();
        we = 2'b00;
        #1;
        for (int g = 0; g < 5; g++) begin
            e = (g == 4) ? 32'h1111 : 32'h2222;
            n_cmp++;
            if (got_rd(g, 0) !== e) begin
                n_err++; $display("FAIL conflict_after: dut%0d got %h exp %h", g, got_rd(g, 0), e);
            end
        end
    endtask

    task automatic test_multi_read();
        for (int i = 1; i <= 4; i++) wr1(5'(i), 32'(9 + i));
        raddr = {5'd4, 5'd3, 5'd2, 5'd1};
        #1;
        for (int g = 0; g < 5; g++)
            for (int r = 0; r < nr(g); r++) begin
                n_cmp++;
                if (got_rd(g, r) !== 32'(10 + r)) begin
                    n_err++; $display("FAIL multi_read: dut%0d p%0d got %h exp %h", g, r, got_rd(g, r), 32'(10 + r));
                end
            end
    endtask

    task automatic sweep_zero(string name);
        for (int i = 0; i < 8; i++) begin
            for (int r = 0; r < 4; r++) raddr[r*5 +: 5] = 5'(i * 4 + r);
            #1;
            for (int g = 0; g < 5; g++)
                for (int r = 0; r < nr(g); r++) begin
                    n_cmp++;
                    if (got_rd(g, r) !== 32'h0) begin
                        n_err++; $display("FAIL %s: dut%0d reg%0d got %h exp 0", name, g, i * 4 + r, got_rd(g, r));
                    end
                end
        end
    endtask

    task automatic test_clear();
        int cnt;
        for (int i = 1; i < 32; i++) wr1(5'(i), 32'(i));
        clear = 1'b1;
        step();
        clear = 1'b0;
        cnt = 0;
        while (busy_g[0] === 1'b1 && cnt < 40) begin
            we = (cnt == 5) ? 2'b11 : 2'b00;
            waddr = {5'd7, 5'd7}; wdata = {32'hAA, 32'hAA};
            clear = (cnt == 12);
            for (int r = 0; r < 4; r++) raddr[r*5 +: 5] = 5'($urandom_range(0, 31));
            #1;
            for (int g = 0; g < 5; g++) begin
                n_cmp++;
                if (got_busy(g) !== 1'b1) begin
                    n_err++; $display("FAIL clear_busy: dut%0d cycle %0d got %b exp 1", g, cnt, got_busy(g));
                end
                for (int r = 0; r < nr(g); r++) begin
                    n_cmp++;
                    if (got_rd(g, r) !== 32'h0) begin
                        n_err++; $display("FAIL clear_rdata: dut%0d p%0d cycle %0d got %h exp 0", g, r, cnt, got_rd(g, r));
                    end
                end
            end
            step();
            cnt++;
        end
        we = 2'b00; clear = 1'b0;
        n_cmp++;
        if (cnt != 32) begin
            n_err++; $display("FAIL clear_length: got %0d cycles exp 32", cnt);
        end
        sweep_zero("clear_result");
    endtask

    task automatic test_reset_mid_clear();
        int cnt;
        for (int i = 1; i < 32; i += 3) wr1(5'(i), $urandom);
        clear = 1'b1;
        step();
        clear = 1'b0;
        repeat (9) step();
        rst_n = 1'b0;
        model_reset();
        raddr = {5'd10, 5'd7, 5'd4, 5'd1};
        #1;
        for (int g = 0; g < 5; g++) begin
            n_cmp++;
            if (got_busy(g) !== 1'b0) begin
                n_err++; $display("FAIL midreset_busy: dut%0d got %b exp 0", g, got_busy(g));
            end
        end
        step();
        rst_n = 1'b1;
        sweep_zero("midreset_rdata");
        clear = 1'b1;
        step();
        clear = 1'b0;
        cnt = 0;
        while (busy_d === 1'b1 && cnt < 40) begin
            step();
            cnt++;
        end
        n_cmp++;
        if (cnt != 32) begin
            n_err++; $display("FAIL midreset_restart_len: got %0d cycles exp 32", cnt);
        end
    endtask

    task automatic test_back_to_back();
        int cnt;
        clear = 1'b1;
        step();
        cnt = 0;
        while (busy_g[3] === 1'b1 && cnt < 40) begin
            step();
            cnt++;
        end
        n_cmp++;
        if (cnt != 32) begin
            n_err++; $display("FAIL held_clear_len: got %0d cycles exp 32", cnt);
        end
        for (int g = 0; g < 5; g++) begin
            n_cmp++;
            if (got_busy(g) !== 1'b0) begin
                n_err++; $display("FAIL held_clear_gap: dut%0d got %b exp 0", g, got_busy(g));
            end
        end
        step();
        clear = 1'b0;
        for (int g = 0; g < 5; g++) begin
            n_cmp++;
            if (got_busy(g) !== 1'b1) begin
                n_err++; $display("FAIL held_clear_restart: dut%0d got %b exp 1", g, got_busy(g));
            end
        end
        cnt = 0;
        while (busy_left > 0 && cnt < 40) begin
            step();
            cnt++;
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            we = 2'($urandom_range(0, 3));
            for (int w = 0; w < 2; w++) begin
                waddr[w*5 +: 5]  = 5'($urandom_range(0, 7));
                wdata[w*32 +: 32] = $urandom;
            end
            for (int r = 0; r < 4; r++) raddr[r*5 +: 5] = 5'($urandom_range(0, 7));
            clear = ($urandom_range(0, 59) == 0);
            #1;
            for (int g = 0; g < 5; g++) begin
                n_cmp++;
                if (got_busy(g) !== (busy_left > 0)) begin
                    n_err++; $display("FAIL rand_busy: dut%0d cycle %0d got %b exp %b", g, c, got_busy(g), busy_left > 0);
                end
                for (int r = 0; r < nr(g); r++) begin
                    n_cmp++;
                    if (got_rd(g, r) !== exp_rd(g, r)) begin
                        n_err++;
                        $display("FAIL rand_rdata: dut%0d p%0d cycle %0d raddr %0d got %h exp %h",
                                 g, r, c, ra(r), got_rd(g, r), exp_rd(g, r));
                    end
                end
            end
            step();
        end
        we = 2'b00; clear = 1'b0;
    endtask

    initial begin
        test_reset();
        test_defaults();
        test_zero_reg();
        test_conflict();
        test_multi_read();
        test_clear();
        test_reset_mid_clear();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
